rob_packet_arbiter: RTL and testbench

- Shares the single 32-bit write channel into the Re-Order Buffer between two packet sources: the Instruction Decoder (4-beat DecoderToRob1..4 message) and the Register Renaming Unit (2-beat RruToRob1..2 message).
- Accepts one whole message per handshake, buffers it, and serializes it beat-by-beat with a packet-type tag.
- Arbitration is round-robin at message granularity; messages are never interleaved.

---
 rtl/rob_packet_arbiter_pkg.sv | 41 ++++
 rtl/rob_packet_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/rob_packet_arbiter.sv | 133 +++++++++++++
 tb/tb_rob_packet_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_packet_arbiter_pkg
// Description : Packet tags, source ids and beat counts for the ROB arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_packet_arbiter_pkg;

    localparam int c_DEC_BEATS = 4;
    localparam int c_RRU_BEATS = 2;

    typedef enum logic [2:0] {
        PT_NONE = 3'd0,
        PT_DEC1 = 3'd1,
        PT_DEC2 = 3'd2,
        PT_DEC3 = 3'd3,
        PT_DEC4 = 3'd4,
        PT_RRU1 = 3'd5,
        PT_RRU2 = 3'd6
    } PacketType_T;

    typedef enum logic {
        SRC_DEC = 1'b0,
        SRC_RRU = 1'b1
    } SourceId_T;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_DEC = 2'd1,
        ST_SEND_RRU = 2'd2
    } ArbState_T;

    // Tag of beat idx (0-based) of a message from src.
    function automatic PacketType_T pkt_type(input SourceId_T src, input logic [2:0] idx);
        logic [2:0] base;
        base = (src == SRC_DEC) ? 3'd1 : 3'd5;
        return PacketType_T'(base + idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_packet_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter; one-hot grant only when advance=1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import rob_packet_arbiter_pkg::*;
#(
    parameter bit FIRST_GRANT = 1'b0
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    SourceId_T  r_last_grant;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (advance) begin
            if (req == 2'b11) begin
                w_grant = (r_last_grant == SRC_RRU) ? 2'b01 : 2'b10;
            end else begin
                w_grant = req;
            end
        end
    end

    assign grant = w_grant;

    // Reset to the opposite of FIRST_GRANT so the first contention favours it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= FIRST_GRANT ? SRC_DEC : SRC_RRU;
        end else if (w_grant != 2'b00) begin
            r_last_grant <= w_grant[1] ? SRC_RRU : SRC_DEC;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rob_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rob_packet_arbiter
// Description : Round-robin arbiter serializing decoder / RRU messages to ROB.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_packet_arbiter
    import rob_packet_arbiter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEC_BEATS   = c_DEC_BEATS,
    parameter int RRU_BEATS   = c_RRU_BEATS,
    parameter int FIRST_GRANT = 0
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          dec_valid,
    output logic                          dec_ready,
    input  logic [DEC_BEATS*DATA_W-1:0]   dec_msg,
    input  logic                          rru_valid,
    output logic                          rru_ready,
    input  logic [RRU_BEATS*DATA_W-1:0]   rru_msg,
    output logic                          rob_valid,
    input  logic                          rob_ready,
    output logic [DATA_W-1:0]             rob_data,
    output logic [2:0]                    rob_type,
    output logic                          rob_last
);

    localparam int BUF_BEATS = (DEC_BEATS > RRU_BEATS) ? DEC_BEATS : RRU_BEATS;
    localparam int BUF_W     = BUF_BEATS * DATA_W;
    localparam int CNT_W     = (BUF_BEATS > 1) ? $clog2(BUF_BEATS) : 1;
    localparam logic [CNT_W-1:0] c_DEC_LAST = CNT_W'(DEC_BEATS - 1);
    localparam logic [CNT_W-1:0] c_RRU_LAST = CNT_W'(RRU_BEATS - 1);

    ArbState_T         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BUF_W-1:0]  r_buf;
    logic              r_rob_valid;
    logic [DATA_W-1:0] r_rob_data;
    PacketType_T       r_rob_type;
    logic              r_rob_last;

    logic              w_hs;
    logic              w_opp;
    logic [1:0]        w_grant;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_last_cnt;
    logic [DATA_W-1:0] w_beat_nxt;
    SourceId_T         w_cur_src;

    assign w_hs  = r_rob_valid && rob_ready;
    assign w_opp = !rst && !flush && ((r_state == ST_IDLE) || (w_hs && r_rob_last));

    rr_arbiter2 #(
        .FIRST_GRANT (FIRST_GRANT != 0)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     ({rru_valid, dec_valid}),
        .advance (w_opp),
        .grant   (w_grant)
    );

    assign dec_ready = w_grant[0];
    assign rru_ready = w_grant[1];

    always_comb begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_cur_src  = (r_state == ST_SEND_RRU) ? SRC_RRU : SRC_DEC;
        w_last_cnt = (r_state == ST_SEND_RRU) ? c_RRU_LAST : c_DEC_LAST;
        w_beat_nxt = r_buf[w_cnt_nxt*DATA_W +: DATA_W];
    end

    // Beat 1 is driven straight from the granted message so a grant in cycle N
    // presents data in N+1; later beats come from the captured buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_rob_valid <= 1'b0;
            r_rob_data  <= '0;
            r_rob_type  <= PT_NONE;
            r_rob_last  <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rob_valid <= 1'b0;
            r_rob_data  <= '0;
            r_rob_type  <= PT_NONE;
            r_rob_last  <= 1'b0;
        end else if (w_grant[0]) begin
            r_state     <= ST_SEND_DEC;
            r_cnt       <= '0;
            r_buf       <= BUF_W'(dec_msg);
            r_rob_valid <= 1'b1;
            r_rob_data  <= dec_msg[DATA_W-1:0];
            r_rob_type  <= pkt_type(SRC_DEC, 3'd0);
            r_rob_last  <= (DEC_BEATS == 1);
        end else if (w_grant[1]) begin
            r_state     <= ST_SEND_RRU;
            r_cnt       <= '0;
            r_buf       <= BUF_W'(rru_msg);
            r_rob_valid <= 1'b1;
            r_rob_data  <= rru_msg[DATA_W-1:0];
            r_rob_type  <= pkt_type(SRC_RRU, 3'd0);
            r_rob_last  <= (RRU_BEATS == 1);
        end else if (w_hs) begin
            if (r_rob_last) begin
                r_state     <= ST_IDLE;
                r_cnt       <= '0;
                r_rob_valid <= 1'b0;
                r_rob_data  <= '0;
                r_rob_type  <= PT_NONE;
                r_rob_last  <= 1'b0;
            end else begin
                r_cnt       <= w_cnt_nxt;
                r_rob_data  <= w_beat_nxt;
                r_rob_type  <= pkt_type(w_cur_src, 3'(w_cnt_nxt));
                r_rob_last  <= (w_cnt_nxt == w_last_cnt);
            end
        end
    end

    assign rob_valid = r_rob_valid;
    assign rob_data  = r_rob_data;
    assign rob_type  = r_rob_type;
    assign rob_last  = r_rob_last;

endmodule
`default_nettype wire

// File: tb/tb_rob_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_packet_arbiter
// Description : Directed bench with a queue-based message model for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_packet_arbiter;

    localparam int DATA_W      = 32;
    localparam int DEC_BEATS   = 4;
    localparam int RRU_BEATS   = 2;
    localparam int FIRST_GRANT = 0;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic                        dec_valid;
    logic                        dec_ready;
    logic [DEC_BEATS*DATA_W-1:0] dec_msg;
    logic                        rru_valid;
    logic                        rru_ready;
    logic [RRU_BEATS*DATA_W-1:0] rru_msg;
    logic                        rob_valid;
    logic                        rob_ready;
    logic [DATA_W-1:0]           rob_data;
    logic [2:0]                  rob_type;
    logic                        rob_last;

    rob_packet_arbiter #(
        .DATA_W      (DATA_W),
        .DEC_BEATS   (DEC_BEATS),
        .RRU_BEATS   (RRU_BEATS),
        .FIRST_GRANT (FIRST_GRANT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .dec_msg   (dec_msg),
        .rru_valid (rru_valid),
        .rru_ready (rru_ready),
        .rru_msg   (rru_msg),
        .rob_valid (rob_valid),
        .rob_ready (rob_ready),
        .rob_data  (rob_data),
        .rob_type  (rob_type),
        .rob_last  (rob_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        ptype;
        logic              last;
    } beat_t;

    beat_t mq[$];
    bit    m_last_rru;
    int    n_vec = 0;
    int    n_err = 0;

    logic              cap_valid, cap_last, cap_dec_ready, cap_rru_ready;
    logic [DATA_W-1:0] cap_data;
    logic [2:0]        cap_type;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs are the head of the pending-beat queue; grants follow the
    // round-robin rule on whole messages.
    task automatic model_step();
        bit    ev, hs, opp, gd, gr;
        beat_t b;
        ev  = (mq.size() != 0);
        hs  = ev && rob_ready;
        opp = !rst && !flush && (!ev || (hs && mq.size() == 1));
        gd  = opp && dec_valid && (!rru_valid || m_last_rru);
        gr  = opp && rru_valid && (!dec_valid || !m_last_rru);
        chk("rob_valid", 64'(rob_valid), 64'(ev));
        chk("dec_ready", 64'(dec_ready), 64'(gd));
        chk("rru_ready", 64'(rru_ready), 64'(gr));
        if (ev) begin
            b = mq[0];
            chk("rob_data", 64'(rob_data), 64'(b.data));
            chk("rob_type", 64'(rob_type), 64'(b.ptype));
            chk("rob_last", 64'(rob_last), 64'(b.last));
        end else begin
            chk("idle_type", 64'(rob_type), 64'd0);
            chk("idle_last", 64'(rob_last), 64'd0);
        end
        cap_valid = rob_valid; cap_data = rob_data; cap_type = rob_type;
        cap_last = rob_last; cap_dec_ready = dec_ready; cap_rru_ready = rru_ready;
        if (rst) begin
            mq.delete();
            m_last_rru = (FIRST_GRANT == 0);
        end else begin
            if (hs) void'(mq.pop_front());
            if (flush) mq.delete();
            if (gd) begin
                for (int i = 0; i < DEC_BEATS; i++) begin
                    b.data = dec_msg[i*DATA_W +: DATA_W];
                    b.ptype = 3'(1 + i);
                    b.last = (i == DEC_BEATS - 1);
                    mq.push_back(b);
                end
                m_last_rru = 1'b0;
            end
            if (gr) begin
                for (int i = 0; i < RRU_BEATS; i++) begin
                    b.data = rru_msg[i*DATA_W +: DATA_W];
                    b.ptype = 3'(5 + i);
                    b.last = (i == RRU_BEATS - 1);
                    mq.push_back(b);
                end
                m_last_rru = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [DATA_W-1:0] exp_words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    int                exp_t2 [13]   = '{0, 1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6};

    initial begin
        rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; rru_valid = 1'b0; rob_ready = 1'b1;
        dec_msg = '0; rru_msg = '0;
        @(posedge clk);
        #1;
        mq.delete();
        m_last_rru = (FIRST_GRANT == 0);
        do_reset();
        chk("reset_valid", 64'(cap_valid), 64'd0);
        chk("reset_data", 64'(cap_data), 64'd0);
        chk("reset_type", 64'(cap_type), 64'd0);

        // Single decoder message
        dec_valid = 1'b1;
        dec_msg = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        step();
        chk("t1_dec_ready", 64'(cap_dec_ready), 64'd1);
        dec_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_valid", 64'(cap_valid), 64'd1);
            chk("t1_data", 64'(cap_data), 64'(exp_words[i]));
            chk("t1_type", 64'(cap_type), 64'(i + 1));
            chk("t1_last", 64'(cap_last), 64'(i == 3));
        end
        step();
        chk("t1_idle", 64'(cap_valid), 64'd0);

        // Both sources contending from reset
        do_reset();
        dec_valid = 1'b1; rru_valid = 1'b1;
        dec_msg = {32'hD0000004, 32'hD0000003, 32'hD0000002, 32'hD0000001};
        rru_msg = {32'hB0000002, 32'hB0000001};
        for (int i = 0; i < 13; i++) begin
            step();
            chk("t2_type", 64'(cap_type), 64'(exp_t2[i]));
            chk("t2_valid", 64'(cap_valid), 64'(i != 0));
            chk("t2_dec_ready", 64'(cap_dec_ready), 64'(i == 0 || i == 6 || i == 12));
            chk("t2_rru_ready", 64'(cap_rru_ready), 64'(i == 4 || i == 10));
            if (cap_dec_ready) dec_msg = dec_msg ^ {4{32'h01000000}};
            if (cap_rru_ready) rru_msg = rru_msg ^ {2{32'h01000000}};
        end
        dec_valid = 1'b0; rru_valid = 1'b0;
        steps(6);

        // Backpressure on RRU beat 1
        rru_valid = 1'b1;
        rru_msg = {32'hAAAA0002, 32'hAAAA0001};
        step();
        chk("t3_rru_ready", 64'(cap_rru_ready), 64'd1);
        rru_valid = 1'b0; rob_ready = 1'b0; dec_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_data", 64'(cap_data), 64'h00000000AAAA0001);
            chk("t3_hold_type", 64'(cap_type), 64'd5);
            chk("t3_hold_last", 64'(cap_last), 64'd0);
            chk("t3_no_ready", 64'({cap_dec_ready, cap_rru_ready}), 64'd0);
        end
        rob_ready = 1'b1; dec_valid = 1'b0;
        step();
        chk("t3_beat1_hs", 64'(cap_data), 64'h00000000AAAA0001);
        step();
        chk("t3_beat2_data", 64'(cap_data), 64'h00000000AAAA0002);
        chk("t3_beat2_type", 64'(cap_type), 64'd6);
        chk("t3_beat2_last", 64'(cap_last), 64'd1);
        step();
        chk("t3_idle", 64'(cap_valid), 64'd0);

        // Flush during DEC2 under backpressure
        dec_valid = 1'b1;
        dec_msg = {32'hC0000004, 32'hC0000003, 32'hC0000002, 32'hC0000001};
        step();
        dec_valid = 1'b0;
        step();
        rob_ready = 1'b0; flush = 1'b1; rru_valid = 1'b1;
        rru_msg = {32'hE0000002, 32'hE0000001};
        step();
        chk("t4_dec2_type", 64'(cap_type), 64'd2);
        chk("t4_no_grant", 64'({cap_dec_ready, cap_rru_ready}), 64'd0);
        flush = 1'b0;
        step();
        chk("t4_flush_valid", 64'(cap_valid), 64'd0);
        chk("t4_flush_type", 64'(cap_type), 64'd0);
        chk("t4_rru_grant", 64'(cap_rru_ready), 64'd1);
        chk("t4_no_dec", 64'(cap_dec_ready), 64'd0);
        rru_valid = 1'b0; rob_ready = 1'b1;
        step();
        chk("t4_rru1", 64'(cap_data), 64'h00000000E0000001);
        steps(3);

        // Reset in the middle of an RRU message
        rru_valid = 1'b1;
        rru_msg = {32'hF0000002, 32'hF0000001};
        step();
        rru_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("t5_pre_rst_type", 64'(cap_type), 64'd6);
        rst = 1'b0; dec_valid = 1'b1; rru_valid = 1'b1;
        step();
        chk("t5_rst_valid", 64'(cap_valid), 64'd0);
        chk("t5_rst_data", 64'(cap_data), 64'd0);
        chk("t5_rst_type", 64'(cap_type), 64'd0);
        chk("t5_first_grant", 64'({cap_rru_ready, cap_dec_ready}), 64'(FIRST_GRANT == 0 ? 1 : 2));
        dec_valid = 1'b0; rru_valid = 1'b0;
        steps(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
